// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmitter between two byte-stream requesters. A
//   requester that wins the grant keeps it for its whole message (until its
//   byte flagged "last" has been sent), so messages are never interleaved.
//   Ties are broken round-robin against the most recent owner.
//
// Ports
//   clk                     rising-edge clock
//   i_reset                 asynchronous, active-high reset
//   i_reqN_valid/data/last  requester N offers a byte (N = 0, 1)
//   o_reqN_ready            byte from requester N is taken this cycle
//   o_tx_start              one-cycle start pulse to the transmitter
//   o_tx_data               byte for the transmitter, held until next accept
//   i_tx_busy               transmitter is shifting a frame
//   o_grant                 one-hot owner, 2'b00 when idle
//   o_timeout               one-cycle pulse when the transmitter never went busy
module uart_tx_arbiter #(
  parameter int DW          = 8,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic          clk,
  input  logic          i_reset,
  input  logic          i_req0_valid,
  input  logic [DW-1:0] i_req0_data,
  input  logic          i_req0_last,
  input  logic          i_req1_valid,
  input  logic [DW-1:0] i_req1_data,
  input  logic          i_req1_last,
  output logic          o_req0_ready,
  output logic          o_req1_ready,
  output logic          o_tx_start,
  output logic [DW-1:0] o_tx_data,
  input  logic          i_tx_busy,
  output logic [1:0]    o_grant,
  output logic          o_timeout
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_CNT = CW'(ACK_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    START,
    ACK,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          recent_q, recent_d;
  logic          last_q, last_d;
  logic [DW-1:0] data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          start_q, start_d;
  logic          timeout_q, timeout_d;
  logic [1:0]    grant_q, grant_d;

  logic          pick_req1;
  logic          accept;
  logic [CW-1:0] cnt_inc;

  // Ready follows i_tx_busy combinationally so a byte is never handed over
  // while the previous frame is still shifting out.
  assign o_req0_ready = (state_q == GRANT) && !owner_q && !i_tx_busy;
  assign o_req1_ready = (state_q == GRANT) &&  owner_q && !i_tx_busy;

  // Requester 1 wins when it is alone, or when both ask and requester 0
  // held the grant most recently.
  assign pick_req1 = i_req1_valid && (!i_req0_valid || !recent_q);

  assign accept  = owner_q ? (i_req1_valid && o_req1_ready)
                           : (i_req0_valid && o_req0_ready);
  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    recent_d  = recent_q;
    last_d    = last_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    start_d   = 1'b0;
    timeout_d = 1'b0;
    grant_d   = grant_q;

    case (state_q)
      IDLE: begin
        if (i_req0_valid || i_req1_valid) begin
          owner_d = pick_req1;
          grant_d = pick_req1 ? 2'b10 : 2'b01;
          state_d = GRANT;
        end
      end

      // The grant is held here for as long as the owner takes; the other
      // requester is simply ignored until the message ends.
      GRANT: begin
        if (accept) begin
          data_d  = owner_q ? i_req1_data : i_req0_data;
          last_d  = owner_q ? i_req1_last : i_req0_last;
          start_d = 1'b1;
          state_d = START;
        end
      end

      START: begin
        cnt_d   = '0;
        state_d = ACK;
      end

      // Give the transmitter ACK_TIMEOUT cycles to acknowledge the start
      // pulse; if it never does, flag it and carry on rather than stall.
      ACK: begin
        if (i_tx_busy) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TIMEOUT_CNT) begin
            timeout_d = 1'b1;
            state_d   = DONE;
          end
        end
      end

      DONE: begin
        if (!i_tx_busy) begin
          if (last_q) begin
            recent_d = owner_q;
            grant_d  = 2'b00;
            state_d  = IDLE;
          end else begin
            state_d = GRANT;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      recent_q  <= 1'b1;
      last_q    <= 1'b0;
      data_q    <= '0;
      cnt_q     <= '0;
      start_q   <= 1'b0;
      timeout_q <= 1'b0;
      grant_q   <= 2'b00;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      recent_q  <= recent_d;
      last_q    <= last_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      start_q   <= start_d;
      timeout_q <= timeout_d;
      grant_q   <= grant_d;
    end
  end

  assign o_tx_start = start_q;
  assign o_tx_data  = data_q;
  assign o_grant    = grant_q;
  assign o_timeout  = timeout_q;

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: DW, 8, byte width of requester and transmitter data.
REQ-002 Parameter: ACK_TIMEOUT, 4, cycles to wait for i_tx_busy to rise after a start pulse.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 i_reset  input  1  asynchronous, active-high reset.
REQ-005 i_req0_valid / i_req1_valid  input  1 each  requester N offers a byte.
REQ-006 i_req0_data / i_req1_data  input  DW each  requester N byte.
REQ-007 i_req0_last / i_req1_last  input  1 each  byte is final of requester N's message.
REQ-008 o_req0_ready / o_req1_ready  output  1 each  arbiter accepts requester N byte this cycle.
REQ-009 o_tx_start  output  1  one-cycle start pulse to UART transmitter.
REQ-010 o_tx_data  output  DW  byte for transmitter; stable from start pulse until next accept.
REQ-011 i_tx_busy  input  1  transmitter shifting a frame.
REQ-012 o_grant  output  2  one-hot current owner; 2'b00 when idle.
REQ-013 o_timeout  output  1  one-cycle pulse when ACK_TIMEOUT expires.

Function
REQ-014 States SHALL be IDLE, GRANT, START, ACK, DONE.
REQ-015 IDLE: if any valid, SHALL select owner and enter GRANT next cycle; o_grant SHALL show owner from GRANT entry.
REQ-016 Selection SHALL be round-robin: both valid -> requester not granted most recently; only one valid -> that one.
REQ-017 GRANT: o_reqN_ready SHALL equal (owner==N && !i_tx_busy); non-owner ready SHALL be 0 in every state.
REQ-018 Accept (valid&&ready) SHALL latch data into o_tx_data, latch last flag, enter START.
REQ-019 GRANT without accept: SHALL hold grant indefinitely (message lock); other requester SHALL wait.
REQ-020 START: o_tx_start SHALL be 1 for exactly one cycle, then enter ACK.
REQ-021 ACK: i_tx_busy=1 -> DONE; else counter increments; on ACK_TIMEOUT cycles without busy SHALL pulse o_timeout and enter DONE.
REQ-022 DONE: wait for i_tx_busy=0; then latched last=1 -> IDLE, record owner as most-recent, o_grant=00; last=0 -> GRANT, same owner.
REQ-023 Latency: valid in IDLE at cycle 0 -> ready at cycle 1 -> o_tx_start at cycle 2 if accepted at cycle 1.
REQ-024 Non-owner valid arriving during owner's message SHALL NOT affect state; serviced on next IDLE.
REQ-025 Owner valid deasserted mid-message SHALL NOT release grant; only accepted last byte releases.
REQ-026 Timeout counter SHALL clear on entry to ACK; width ceil(log2(ACK_TIMEOUT+1)).

Reset
REQ-027 i_reset=1 SHALL immediately force IDLE, o_grant=00, o_req0_ready=o_req1_ready=0, o_tx_start=0, o_tx_data=0, o_timeout=0, counter=0, most-recent owner=requester 1 (requester 0 wins first tie).
REQ-028 Reset mid-message SHALL discard latched byte without start pulse; transmitter frame in flight is not the arbiter's concern.

Verification
REQ-029 Both valid at cycle 0 after reset, single-byte messages 0x41 (req0), 0x42 (req1), busy model 10 cycles -> transmit order 0x41 then 0x42; o_grant 01 then 10.
REQ-030 req0 sends 3-byte message 0x10,0x11,0x12(last) while req1 valid throughout -> all three req0 bytes before any req1 byte; o_req1_ready never 1 meanwhile.
REQ-031 Single valid 0x55 at cycle 0 -> o_req0_ready at cycle 1, o_tx_start=1 at cycle 2 with o_tx_data=0x55, single-cycle pulse.
REQ-032 Busy model never asserts i_tx_busy -> o_timeout pulse exactly ACK_TIMEOUT(4) cycles after ACK entry; arbiter returns to IDLE for last byte.
REQ-033 Assert i_reset in ACK state mid-message -> outputs at reset values same cycle; after release, pending req0 granted first.
REQ-034 req1 drops valid for 20 cycles mid-message while req0 valid -> o_grant stays 10; req1 resumes and finishes before req0 granted.
